// File: rtl/audio_pkg.sv
// Shared definitions for the I2S audio path (serializer and receiver).
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, slot/sample widths, the stereo pair struct
// and a helper that tells whether a slot position carries a sample bit.
package audio_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int SLOT_W     = 32;
  localparam int SLOT_POS_W = $clog2(SLOT_W);       // position within a slot
  localparam int BIT_CNT_W  = $clog2(2 * SLOT_W);   // position within a frame

  // Serializer FSM encoding.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    sample_t left;
    sample_t right;
  } pair_t;

  // I2S places the sample MSB one bit after the slot boundary, so slot
  // positions 1..SAMPLE_W carry data and every other position is zero.
  function automatic logic in_sample_window(input logic [SLOT_POS_W-1:0] pos);
    return (pos >= SLOT_POS_W'(1)) && (pos <= SLOT_POS_W'(SAMPLE_W));
  endfunction

endpackage

// File: rtl/audio_clk_gen.sv
// Bit-clock divider and frame bit counter for the I2S serializer.
// Latency: bclk toggles every DIV state_clk cycles while run is high.
// Backpressure: none; free-running once started, held at 0 while idle.
//
// Ports:
//   state_clk, reset_n : clock and asynchronous active-low reset
//   start              : first pair accepted while idle (frame begins)
//   run                : serializer is streaming frames
//   bclk               : codec bit clock, low first after start
//   lr_clk             : frame clock, 0 = left slot, 1 = right slot
//   bclk_fall          : strobe, high in the cycle whose closing edge drops bclk
//   bit_cnt            : bit position within the 64-bit frame
module audio_clk_gen
  import audio_pkg::*;
#(
  parameter int DIV = 4   // state_clk cycles per bclk half-period, 2..255
) (
  input  logic                 state_clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 run,
  output logic                 bclk,
  output logic                 lr_clk,
  output logic                 bclk_fall,
  output logic [BIT_CNT_W-1:0] bit_cnt
);

  localparam int                DIV_W    = $clog2(DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0]     div_cnt;
  logic                 div_tc;
  logic [BIT_CNT_W-1:0] bit_nxt;

  assign div_tc    = run && (div_cnt == DIV_LAST);
  assign bclk_fall = div_tc && bclk;
  assign bit_nxt   = bit_cnt + BIT_CNT_W'(1);

  always_ff @(posedge state_clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      bit_cnt <= '0;
      lr_clk  <= 1'b1;
    end else if (run) begin
      div_cnt <= div_tc ? '0 : div_cnt + DIV_W'(1);
      if (div_tc) begin
        bclk <= !bclk;
      end
      // bit_cnt wraps 63 -> 0; lr_clk follows its MSB so every lr_clk
      // change lands on a bclk falling edge.
      if (bclk_fall) begin
        bit_cnt <= bit_nxt;
        lr_clk  <= bit_nxt[BIT_CNT_W-1];
      end
    end else if (start) begin
      // Leaving idle opens the left slot of the first frame at bit 0.
      lr_clk <= 1'b0;
    end
  end

endmodule

// File: rtl/audio_dac_serializer.sv
// I2S serializer: stereo 16-bit pairs in, 64-bit-frame serial data out.
// Latency: first pair goes out immediately; later pairs go out in the frame after acceptance.
// Backpressure: sample_ready low while the one-deep holding register is full.
//
// Ports:
//   state_clk, reset_n     : clock and asynchronous active-low reset
//   left_in, right_in      : 2's complement samples, captured together
//   sample_valid           : pair on left_in/right_in is valid
//   sample_ready           : holding register empty, a pair can be taken
//   bclk, lr_clk           : codec bit clock and frame clock
//   dac_data               : serial data, changes only on bclk falling edges
//   underrun               : one-cycle pulse when a frame repeats the last pair
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int DIV = 4   // state_clk cycles per bclk half-period, 2..255
) (
  input  logic                state_clk,
  input  logic                reset_n,
  input  logic [SAMPLE_W-1:0] left_in,
  input  logic [SAMPLE_W-1:0] right_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                bclk,
  output logic                lr_clk,
  output logic                dac_data,
  output logic                underrun
);

  logic [0:0]           state;
  pair_t                in_pair;
  pair_t                hold_dat;
  logic                 hold_vld;
  pair_t                tx_dat;
  sample_t              shift_q;
  sample_t              slot_src;
  logic                 accept;
  logic                 start;
  logic                 run;
  logic                 bclk_fall;
  logic                 frame_start;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [BIT_CNT_W-1:0] bit_nxt;
  logic [SLOT_POS_W-1:0] pos_nxt;

  assign in_pair      = {left_in, right_in};
  assign sample_ready = !hold_vld;
  assign accept       = sample_valid && sample_ready;
  assign run          = (state == ST_RUN);
  assign start        = (state == ST_IDLE) && accept;
  assign frame_start  = bclk_fall && (bit_cnt == '1);

  // Slot position that becomes current at the coming bclk falling edge.
  assign bit_nxt  = bit_cnt + BIT_CNT_W'(1);
  assign pos_nxt  = bit_nxt[SLOT_POS_W-1:0];
  assign slot_src = bit_nxt[BIT_CNT_W-1] ? tx_dat.right : tx_dat.left;

  audio_clk_gen #(
    .DIV (DIV)
  ) u_clk_gen (
    .state_clk (state_clk),
    .reset_n   (reset_n),
    .start     (start),
    .run       (run),
    .bclk      (bclk),
    .lr_clk    (lr_clk),
    .bclk_fall (bclk_fall),
    .bit_cnt   (bit_cnt)
  );

  // Control: FSM, holding register and the frame pair (tx_dat).
  always_ff @(posedge state_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      hold_vld <= 1'b0;
      hold_dat <= '0;
      tx_dat   <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (state == ST_IDLE) begin
        // The very first pair bypasses the holding register.
        if (accept) begin
          tx_dat <= in_pair;
          state  <= ST_RUN;
        end
      end else if (frame_start) begin
        if (hold_vld) begin
          tx_dat   <= hold_dat;
          hold_vld <= 1'b0;
        end else if (accept) begin
          // Pair arriving exactly at the boundary goes straight out.
          tx_dat <= in_pair;
        end else begin
          // Nothing new: tx_dat is left alone, so the last pair repeats.
          underrun <= 1'b1;
        end
      end else if (accept) begin
        hold_dat <= in_pair;
        hold_vld <= 1'b1;
      end
    end
  end

  // Datapath: per-slot shifter. tx_dat is only replaced at slot position 0
  // of the left slot, so both slots of a frame come from the same pair.
  always_ff @(posedge state_clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q  <= '0;
      dac_data <= 1'b0;
    end else if (run && bclk_fall) begin
      if (pos_nxt == SLOT_POS_W'(1)) begin
        dac_data <= slot_src[SAMPLE_W-1];
        shift_q  <= {slot_src[SAMPLE_W-2:0], 1'b0};
      end else if (in_sample_window(pos_nxt)) begin
        dac_data <= shift_q[SAMPLE_W-1];
        shift_q  <= {shift_q[SAMPLE_W-2:0], 1'b0};
      end else begin
        dac_data <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Self-checking bench for audio_dac_serializer with DIV=2.
// A frame-level reference model predicts every output each cycle.
// Scenarios: reset/idle, bit order, underrun, simultaneous load, back-pressure, mid-frame reset.
module tb_audio_dac_serializer;

  localparam int DIV = 2;
  localparam int T   = 128 * DIV;   // state_clk cycles per frame

  logic        state_clk    = 1'b0;
  logic        reset_n      = 1'b0;
  logic [15:0] left_in      = '0;
  logic [15:0] right_in     = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        bclk;
  logic        lr_clk;
  logic        dac_data;
  logic        underrun;

  audio_dac_serializer #(.DIV(DIV)) dut (
    .state_clk    (state_clk),
    .reset_n      (reset_n),
    .left_in      (left_in),
    .right_in     (right_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .bclk         (bclk),
    .lr_clk       (lr_clk),
    .dac_data     (dac_data),
    .underrun     (underrun)
  );

  always #5 state_clk = ~state_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // m_n counts clock edges since the frame that left idle began; all output
  // timing is derived from it arithmetically. m_pend holds pairs accepted
  // during the current frame, waiting for the next frame.
  bit          m_run  = 1'b0;
  int          m_n    = 0;
  logic [31:0] m_cur  = '0;
  logic [31:0] m_pend[$];
  bit          m_urun = 1'b0;
  bit          m_acc  = 1'b0;

  always @(posedge state_clk or negedge reset_n) begin
    if (!reset_n) begin
      m_run  = 1'b0;
      m_n    = 0;
      m_urun = 1'b0;
      m_acc  = 1'b0;
      m_pend.delete();
    end else begin
      m_acc  = sample_valid && (m_pend.size() == 0);
      m_urun = 1'b0;
      if (!m_run) begin
        if (m_acc) begin
          m_run = 1'b1;
          m_n   = 0;
          m_cur = {left_in, right_in};
        end
      end else begin
        m_n++;
        if (m_n % T == 0) begin
          if (m_pend.size() != 0) m_cur = m_pend.pop_front();
          else if (m_acc)         m_cur = {left_in, right_in};
          else                    m_urun = 1'b1;
        end else if (m_acc) begin
          m_pend.push_back({left_in, right_in});
        end
      end
    end
  end

  // ---------------- per-cycle output check ----------------
  bit          chk_en = 1'b0;
  logic        c_bclk, c_lr, c_dac, c_rdy, c_urun;
  int          c_bp, c_k;
  logic [15:0] c_s;

  always @(negedge state_clk) begin
    #1;
    if (chk_en) begin
      if (!reset_n || !m_run) begin
        c_bclk = 1'b0;
        c_lr   = 1'b1;
        c_dac  = 1'b0;
      end else begin
        c_bp   = (m_n / (2 * DIV)) % 64;
        c_k    = c_bp % 32;
        c_bclk = ((m_n / DIV) % 2) == 1;
        c_lr   = (c_bp >= 32);
        c_s    = c_lr ? m_cur[15:0] : m_cur[31:16];
        c_dac  = (c_k >= 1 && c_k <= 16) ? c_s[16 - c_k] : 1'b0;
      end
      c_rdy  = !reset_n ? 1'b1 : (m_pend.size() == 0);
      c_urun = !reset_n ? 1'b0 : m_urun;
      check_eq("cyc_bclk",     bclk,         c_bclk);
      check_eq("cyc_lr_clk",   lr_clk,       c_lr);
      check_eq("cyc_dac_data", dac_data,     c_dac);
      check_eq("cyc_ready",    sample_ready, c_rdy);
      check_eq("cyc_underrun", underrun,     c_urun);
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [63:0] frame_bits(input logic [15:0] l, input logic [15:0] r);
    return {1'b0, l, 15'd0, 1'b0, r, 15'd0};
  endfunction

  // Called at a negedge; leaves valid low one negedge later.
  task automatic send_pair(input logic [15:0] l, input logic [15:0] r);
    left_in      = l;
    right_in     = r;
    sample_valid = 1'b1;
    @(negedge state_clk);
    sample_valid = 1'b0;
  endtask

  // Samples T consecutive negedges, starting with the current one, latching
  // dac_data at each bclk rising edge (where the codec samples it).
  logic g_prev_bclk = 1'b0;
  task automatic grab_frame(output logic [63:0] bits, output int rises,
                            output int uruns, output int busy);
    bits  = '0;
    rises = 0;
    uruns = 0;
    busy  = 0;
    for (int i = 0; i < T; i++) begin
      if (bclk && !g_prev_bclk) begin
        bits = {bits[62:0], dac_data};
        rises++;
      end
      g_prev_bclk = bclk;
      if (underrun)      uruns++;
      if (!sample_ready) busy++;
      @(negedge state_clk);
    end
  endtask

  task automatic wait_until(input int target, input string tag);
    int guard = 0;
    while (!(m_run && m_n == target) && guard < 20000) begin
      @(negedge state_clk);
      guard++;
    end
    check_eq(tag, (m_run && m_n == target), 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] bits;
    int          rises, uruns, busy, tog, hs_cnt, ur_cnt;
    logic [2:0]  prev;
    logic [15:0] l, r;
    bit          prev_hs, hs;
    logic        rdy_after_first;

    chk_en = 1'b1;

    // Reset and idle.
    reset_n = 1'b0;
    repeat (5) @(negedge state_clk);
    reset_n = 1'b1;
    tog  = 0;
    prev = {bclk, lr_clk, dac_data};
    repeat (1000) begin
      @(negedge state_clk);
      if ({bclk, lr_clk, dac_data} != prev) tog++;
      prev = {bclk, lr_clk, dac_data};
    end
    check_eq("idle_toggles", tog, 0);
    check_eq("idle_bclk", bclk, 1'b0);
    check_eq("idle_lr_clk", lr_clk, 1'b1);
    check_eq("idle_dac", dac_data, 1'b0);
    check_eq("idle_ready", sample_ready, 1'b1);

    // Bit order, then two underrun frames repeating the same pair.
    send_pair(16'hA5C3, 16'h8001);
    grab_frame(bits, rises, uruns, busy);
    check_eq("f0_bits", bits, frame_bits(16'hA5C3, 16'h8001));
    check_eq("f0_bclk_rises", rises, 64);
    check_eq("f0_underrun", uruns, 0);
    grab_frame(bits, rises, uruns, busy);
    check_eq("f1_repeat_bits", bits, frame_bits(16'hA5C3, 16'h8001));
    check_eq("f1_underrun", uruns, 1);
    check_eq("f1_ready_low", busy, 0);
    grab_frame(bits, rises, uruns, busy);
    check_eq("f2_underrun", uruns, 1);
    check_eq("f2_ready_low", busy, 0);

    // Valid exactly at the frame boundary with nothing held.
    wait_until(4 * T - 1, "wait_simul");
    l = 16'($urandom);
    r = 16'($urandom);
    send_pair(l, r);
    grab_frame(bits, rises, uruns, busy);
    check_eq("simul_bits", bits, frame_bits(l, r));
    check_eq("simul_underrun", uruns, 0);

    // Back-pressure: valid held high with an incrementing pair.
    wait_until(5 * T + 10, "wait_bp");
    left_in         = 16'($urandom);
    right_in        = 16'($urandom);
    sample_valid    = 1'b1;
    prev_hs         = 1'b0;
    hs_cnt          = 0;
    ur_cnt          = 0;
    rdy_after_first = 1'b1;
    for (int i = 0; i < 1270; i++) begin
      if (i > 0) begin
        @(negedge state_clk);
        if (prev_hs) begin
          left_in  = left_in + 16'd1;
          right_in = right_in + 16'h0101;
        end
      end
      if (i == 1) rdy_after_first = sample_ready;
      hs = sample_valid && sample_ready;
      if (hs)       hs_cnt++;
      if (underrun) ur_cnt++;
      prev_hs = hs;
    end
    @(negedge state_clk);
    sample_valid = 1'b0;
    check_eq("bp_ready_drop", rdy_after_first, 1'b0);
    check_eq("bp_accepts", hs_cnt, 5);
    check_eq("bp_underrun", ur_cnt, 0);

    // Fill the holding register, then reset mid right slot (bit 20).
    wait_until(11 * T + 100, "wait_hold");
    send_pair(16'($urandom), 16'($urandom));
    wait_until(11 * T + 209, "wait_rst");
    reset_n = 1'b0;
    #1;
    check_eq("rst_bclk", bclk, 1'b0);
    check_eq("rst_lr_clk", lr_clk, 1'b1);
    check_eq("rst_dac", dac_data, 1'b0);
    check_eq("rst_ready", sample_ready, 1'b1);
    check_eq("rst_underrun", underrun, 1'b0);
    repeat (3) @(negedge state_clk);
    reset_n = 1'b1;
    repeat (20) @(negedge state_clk);
    l = 16'($urandom);
    r = 16'($urandom);
    send_pair(l, r);
    grab_frame(bits, rises, uruns, busy);
    check_eq("post_rst_bits", bits, frame_bits(l, r));
    grab_frame(bits, rises, uruns, busy);
    check_eq("post_rst_repeat", bits, frame_bits(l, r));
    check_eq("post_rst_underrun", uruns, 1);

    repeat (4) @(negedge state_clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
